// File: rtl/aes_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
// Module  : aes_shift_rows_pipe
// Brief   : Registered ShiftRows / InvShiftRows / bypass stage for a Rijndael
//           state of NB columns, with a 2-entry valid/ready skid buffer so
//           that in_ready comes straight from a flop.
// Rev     : 1.0  initial release
// ============================================================================
module aes_shift_rows_pipe #(
    parameter int NB     = 4,
    parameter bit ERR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NB-1:0]  in_data,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic              err,
    input  logic              err_clr
);

    localparam int c_W = 32 * NB;

    localparam logic [1:0] c_MODE_FWD = 2'b00;
    localparam logic [1:0] c_MODE_INV = 2'b01;
    localparam logic [1:0] c_MODE_RSV = 2'b11;

    // Occupancy of the output register plus skid register.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [c_W-1:0]   r_out_data;
    logic [c_W-1:0]   r_skid_data;

    logic [c_W-1:0]   w_fwd;
    logic [c_W-1:0]   w_inv;
    logic [c_W-1:0]   w_shifted;
    logic             w_accept;
    logic             w_deliver;

    // Only the three Rijndael block widths with defined row offsets exist.
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end

    // Pure wiring: each output byte picks one input byte chosen at elaboration.
    // Byte k sits at row k%4, column k/4, most significant byte first.
    for (genvar k = 0; k < 4 * NB; k++) begin : g_byte
        localparam int c_ROW   = k % 4;
        localparam int c_COL   = k / 4;
        localparam int c_OFF   = (NB == 8) ? ((c_ROW == 3) ? 4 :
                                              (c_ROW == 2) ? 3 : c_ROW)
                                           : c_ROW;
        localparam int c_FWD_K = 4 * ((c_COL + c_OFF) % NB) + c_ROW;
        localparam int c_INV_K = 4 * ((c_COL - c_OFF + NB) % NB) + c_ROW;

        assign w_fwd[c_W-1-8*k -: 8] = in_data[c_W-1-8*c_FWD_K -: 8];
        assign w_inv[c_W-1-8*k -: 8] = in_data[c_W-1-8*c_INV_K -: 8];
    end

    // Direction select on the input side; reserved mode passes data through.
    always_comb begin
        w_shifted = in_data;
        case (in_mode)
            c_MODE_FWD: w_shifted = w_fwd;
            c_MODE_INV: w_shifted = w_inv;
            default:    w_shifted = in_data;
        endcase
    end

    assign w_accept  = in_valid & r_in_ready;
    assign w_deliver = r_out_valid & out_ready;

    // Occupancy FSM; the output register always holds the oldest beat,
    // the skid register only fills when a beat arrives while the output stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_skid_data <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_out_data  <= w_shifted;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_deliver) begin
                        r_out_data <= w_shifted;
                    end else if (w_accept) begin
                        r_skid_data <= w_shifted;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_TWO;
                    end else if (w_deliver) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_deliver) begin
                        r_out_data <= r_skid_data;
                        r_in_ready <= 1'b1;
                        r_state    <= S_ONE;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    if (ERR_EN) begin : g_err
        logic r_err;

        // Sticky flag for accepted reserved-mode beats; a new set beats a clear.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_err <= 1'b0;
            end else if (w_accept && (in_mode == c_MODE_RSV)) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end

        assign err = r_err;
    end else begin : g_no_err
        assign err = 1'b0;
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_aes_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_shift_rows_pipe
// Brief   : Self-checking bench for aes_shift_rows_pipe at NB = 4, 6 and 8.
//           Expected beats are queued on acceptance and compared on delivery.
// Rev     : 1.0  initial release
// ============================================================================
module tb_aes_shift_rows_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [2:0]   in_valid;
    logic [2:0]   out_ready;
    logic [2:0]   err_clr;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [2:0]   err;
    logic [255:0] in_data [3];
    logic [1:0]   in_mode [3];

    logic [127:0] od4;
    logic [191:0] od6;
    logic [255:0] od8;

    logic [255:0] stim_d [$];
    logic [1:0]   stim_m [$];
    logic [255:0] stim_e [$];
    logic [255:0] exp_q  [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    aes_shift_rows_pipe #(.NB(4), .ERR_EN(1'b1)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0][127:0]), .in_mode(in_mode[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(od4), .err(err[0]), .err_clr(err_clr[0])
    );

    aes_shift_rows_pipe #(.NB(6), .ERR_EN(1'b1)) u_dut6 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1][191:0]), .in_mode(in_mode[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(od6), .err(err[1]), .err_clr(err_clr[1])
    );

    aes_shift_rows_pipe #(.NB(8), .ERR_EN(1'b1)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_mode(in_mode[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(od8), .err(err[2]), .err_clr(err_clr[2])
    );

    function automatic logic [255:0] out_of(input int idx);
        case (idx)
            0:       return {128'd0, od4};
            1:       return {64'd0, od6};
            default: return od8;
        endcase
    endfunction

    function automatic logic [255:0] rand_state(input int nb);
        logic [255:0] r;
        logic [255:0] m;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        m = '1;
        if (nb < 8) m = m >> (256 - 32 * nb);
        return r & m;
    endfunction

    // Row-rotation model: gather each row, rotate it left (fwd) or scatter
    // it right (inv) by the row offset of the block width.
    function automatic logic [255:0] ref_shift(input logic [255:0] x, input int nb,
                                               input logic [1:0] mode);
        logic [7:0]   st [4][8];
        logic [7:0]   row [8];
        logic [255:0] y;
        int           offs8 [4];
        int           w;
        int           sh;
        offs8 = '{0, 1, 3, 4};
        w = 32 * nb;
        y = '0;
        if (mode[1]) return x;
        for (int k = 0; k < 4 * nb; k++) st[k % 4][k / 4] = x[w-1-8*k -: 8];
        for (int r = 0; r < 4; r++) begin
            sh = (nb == 8) ? offs8[r] : r;
            for (int c = 0; c < nb; c++) row[c] = st[r][c];
            for (int c = 0; c < nb; c++) begin
                if (mode == 2'b00) st[r][c] = row[(c + sh) % nb];
                else               st[r][(c + sh) % nb] = row[c];
            end
        end
        for (int k = 0; k < 4 * nb; k++) y[w-1-8*k -: 8] = st[k % 4][k / 4];
        return y;
    endfunction

    task automatic clear_stim();
        stim_d.delete();
        stim_m.delete();
        stim_e.delete();
    endtask

    task automatic push_beat(input logic [255:0] d, input logic [1:0] m, input logic [255:0] e);
        stim_d.push_back(d);
        stim_m.push_back(m);
        stim_e.push_back(e);
    endtask

    // Streams the queued beats into one DUT; rdy_mode 0 = always ready,
    // 1 = random backpressure. Called just after a rising edge.
    task automatic run_stream(input int idx, input int rdy_mode, input string tag,
                              output int cycles);
        logic [255:0] act;
        logic [255:0] expv;
        bit           done;
        int           cyc;
        done = 1'b0;
        for (cyc = 0; cyc < 5000 && !done; cyc++) begin
            if (stim_d.size() > 0) begin
                in_valid[idx] = 1'b1;
                in_data[idx]  = stim_d[0];
                in_mode[idx]  = stim_m[0];
            end else begin
                in_valid[idx] = 1'b0;
                in_data[idx]  = rand_state(8);
                in_mode[idx]  = 2'($urandom_range(0, 3));
            end
            out_ready[idx] = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid[idx] && out_ready[idx]) begin
                act = out_of(idx);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL %s extra_beat: got %h, required no beat", tag, act);
                end else begin
                    expv = exp_q.pop_front();
                    if (act !== expv) begin
                        n_errors++;
                        $display("FAIL %s data: got %h, required %h", tag, act, expv);
                    end
                end
            end
            if (in_valid[idx] && in_ready[idx]) begin
                exp_q.push_back(stim_e.pop_front());
                void'(stim_d.pop_front());
                void'(stim_m.pop_front());
            end
            if (stim_d.size() == 0 && exp_q.size() == 0) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid[idx]  = 1'b0;
        out_ready[idx] = 1'b0;
        cycles = cyc;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s timeout: %0d beats unsent, %0d undelivered, required 0 and 0",
                     tag, stim_d.size(), exp_q.size());
            clear_stim();
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1 || err[i] !== 1'b0 ||
                out_of(i) !== 256'd0) begin
                n_errors++;
                $display("FAIL reset dut%0d: got valid=%b ready=%b err=%b data=%h, required 0 1 0 0",
                         i, out_valid[i], in_ready[i], err[i], out_of(i));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_vectors_nb4();
        logic [255:0] x, f, v;
        int cyc;
        x = 256'h00112233445566778899aabbccddeeff;
        f = 256'h0055aaff4499ee3388dd2277cc1166bb;
        v = 256'h00ddaa774411eebb885522ffcc996633;
        clear_stim();
        push_beat(x, 2'b00, f);
        push_beat(x, 2'b01, v);
        push_beat(f, 2'b01, x);
        push_beat(v, 2'b00, x);
        run_stream(0, 0, "vectors_nb4", cyc);
        n_checks++;
        if (cyc != 5) begin
            n_errors++;
            $display("FAIL vectors_nb4 latency: got %0d cycles, required 5", cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] x;
        logic [1:0]   m;
        int cyc;
        clear_stim();
        for (int i = 0; i < 16; i++) begin
            x = rand_state(4);
            m = 2'($urandom_range(0, 2));
            push_beat(x, m, ref_shift(x, 4, m));
        end
        run_stream(0, 0, "back_to_back", cyc);
        n_checks++;
        if (cyc != 17) begin
            n_errors++;
            $display("FAIL back_to_back throughput: got %0d cycles, required 17", cyc);
        end
    endtask

    task automatic test_roundtrip(input int idx, input int nb);
        logic [255:0] x, y;
        int cyc;
        clear_stim();
        for (int i = 0; i < 250; i++) begin
            x = rand_state(nb);
            y = ref_shift(x, nb, 2'b00);
            push_beat(x, 2'b00, y);
            push_beat(y, 2'b01, x);
        end
        run_stream(idx, 1, $sformatf("roundtrip_nb%0d", nb), cyc);
    endtask

    task automatic test_backpressure();
        logic [255:0] b [8];
        logic [1:0]   m [8];
        logic [255:0] e [8];
        int acc;
        int cyc;
        for (int i = 0; i < 8; i++) begin
            b[i] = rand_state(4);
            m[i] = 2'($urandom_range(0, 2));
            e[i] = ref_shift(b[i], 4, m[i]);
        end
        acc = 0;
        out_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = b[acc];
            in_mode[0]  = m[acc];
            @(negedge clk);
            n_checks++;
            if (in_ready[0] !== (i < 2)) begin
                n_errors++;
                $display("FAIL backpressure in_ready cycle%0d: got %b, required %b",
                         i, in_ready[0], (i < 2));
            end
            if (i > 0) begin
                n_checks++;
                if (out_valid[0] !== 1'b1 || out_of(0) !== e[0]) begin
                    n_errors++;
                    $display("FAIL backpressure hold cycle%0d: got valid=%b data=%h, required 1 %h",
                             i, out_valid[0], out_of(0), e[0]);
                end
            end
            if (in_valid[0] && in_ready[0] && acc < 8) begin
                exp_q.push_back(e[acc]);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        clear_stim();
        for (int i = acc; i < 8; i++) push_beat(b[i], m[i], e[i]);
        run_stream(0, 1, "backpressure", cyc);
    endtask

    task automatic test_err();
        logic [255:0] x;
        int cyc;
        n_checks++;
        if (err[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL err_idle: got %b, required 0", err[0]);
        end
        clear_stim();
        for (int i = 0; i < 4; i++) begin
            x = rand_state(4);
            push_beat(x, 2'b10, x);
        end
        run_stream(0, 1, "bypass", cyc);
        n_checks++;
        if (err[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL err_bypass: got %b, required 0", err[0]);
        end
        clear_stim();
        x = rand_state(4);
        push_beat(x, 2'b11, x);
        run_stream(0, 1, "reserved", cyc);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (err[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL err_sticky: got %b, required 1", err[0]);
        end
        err_clr[0] = 1'b1;
        @(posedge clk);
        #1;
        err_clr[0] = 1'b0;
        n_checks++;
        if (err[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL err_clear: got %b, required 0", err[0]);
        end
        // Reserved beat and clear in the same cycle: the set must win.
        x = rand_state(4);
        in_valid[0]  = 1'b1;
        in_data[0]   = x;
        in_mode[0]   = 2'b11;
        err_clr[0]   = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        err_clr[0]  = 1'b0;
        n_checks++;
        if (err[0] !== 1'b1 || out_valid[0] !== 1'b1 || out_of(0) !== x) begin
            n_errors++;
            $display("FAIL err_set_wins: got err=%b valid=%b data=%h, required 1 1 %h",
                     err[0], out_valid[0], out_of(0), x);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_in_two();
        logic [255:0] x;
        int cyc;
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_mode[0]   = 2'b11;
        for (int i = 0; i < 2; i++) begin
            in_data[0] = rand_state(4);
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0;
        n_checks++;
        if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || err[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL two_full: got ready=%b valid=%b err=%b, required 0 1 1",
                     in_ready[0], out_valid[0], err[0]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (out_valid[0] !== 1'b0 || err[0] !== 1'b0 || out_of(0) !== 256'd0) begin
            n_errors++;
            $display("FAIL reset_in_two: got valid=%b err=%b data=%h, required 0 0 0",
                     out_valid[0], err[0], out_of(0));
        end
        @(negedge clk);
        n_checks++;
        if (in_ready[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready: got %b, required 1", in_ready[0]);
        end
        out_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_discard cycle%0d: got valid=%b, required 0", i, out_valid[0]);
            end
        end
        @(posedge clk);
        #1;
        clear_stim();
        for (int i = 0; i < 4; i++) begin
            x = rand_state(4);
            push_beat(x, 2'b00, ref_shift(x, 4, 2'b00));
        end
        run_stream(0, 1, "after_reset", cyc);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid  = '0;
        out_ready = '0;
        err_clr   = '0;
        for (int i = 0; i < 3; i++) begin
            in_data[i] = '0;
            in_mode[i] = 2'b00;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_vectors_nb4();
        test_back_to_back();
        test_roundtrip(1, 6);
        test_roundtrip(2, 8);
        test_backpressure();
        test_err();
        test_reset_in_two();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
